// File: rtl/ad9866_pkg.sv
// Shared constants and the frame-FSM state type for the AD9866 control-port responder.
package ad9866_pkg;

  localparam int AD9866_NREGS = 20;

  localparam logic [4:0] ADDR_SPI_CFG = 5'h00;
  localparam logic [4:0] ADDR_RX_GAIN = 5'h0a;
  localparam logic [4:0] ADDR_TX_GAIN = 5'h11;

  // Bit positions within the 16-bit frame {rw, 2'b00, addr[4:0], data[7:0]}
  localparam int RW_BIT   = 15;
  localparam int ADDR_MSB = 12;
  localparam int ADDR_LSB = 8;

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} spi_slv_state_t;

endpackage

// File: rtl/ad9866_spi_slv_shift.sv
// SPI clock edge detection, 4-bit rise counter and MSB-first input shift register.
// sr already includes the bit sampled on the current rise, so header/data are usable on the strobe clk.
module ad9866_spi_slv_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        sen_n,
  input  logic        sdio,
  input  logic        count_en,
  output logic        fall,
  output logic        hdr_done,
  output logic        frame_done,
  output logic [15:0] sr
);

  logic        sclk_q;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [15:0] sr_q, sr_d;
  logic        rise;

  always_comb begin
    rise       = sclk & ~sclk_q & ~sen_n;
    fall       = ~sclk & sclk_q & ~sen_n;
    bitcnt_d   = bitcnt_q;
    sr_d       = sr_q;
    hdr_done   = 1'b0;
    frame_done = 1'b0;
    if (sen_n) begin
      bitcnt_d = 4'd0;
    end else if (rise && count_en) begin
      sr_d       = {sr_q[14:0], sdio};
      hdr_done   = (bitcnt_q == 4'd7);
      frame_done = (bitcnt_q == 4'd15);
      // Saturate so a stray extra rise can never start counting a second frame
      if (bitcnt_q != 4'd15) bitcnt_d = bitcnt_q + 4'd1;
    end
  end

  assign sr = sr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q   <= 1'b0;
      bitcnt_q <= 4'd0;
      sr_q     <= 16'd0;
    end else begin
      sclk_q   <= sclk;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
    end
  end

endmodule

// File: rtl/ad9866_spi_responder.sv
// AD9866 control-port emulation: frame FSM, NREGS x 8 register file and optional serial readback.
// Readback (rd_sr and a live sdo) is built only when AD9866_SPI_READBACK_EN is defined.
module ad9866_spi_responder
  import ad9866_pkg::*;
#(
  parameter int                   NREGS     = AD9866_NREGS,
  parameter logic [NREGS*8-1:0]   RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               sen_n,
  input  logic               sdio,
  output logic               sdo,
  output logic [NREGS*8-1:0] regs,
  output logic               wr_stb,
  output logic [4:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               addr_err,
  output logic [5:0]         rx_gain
);

  localparam int RX_GAIN_LSB = int'(ADDR_RX_GAIN) * 8;

  spi_slv_state_t     state_q, state_d;
  logic               rw_q, rw_d;
  logic [4:0]         addr_q, addr_d;
  logic [NREGS*8-1:0] regs_q, regs_d;
  logic               wr_stb_q, wr_stb_d;
  logic [4:0]         wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               addr_err_q, addr_err_d;

  logic        fall, hdr_done, frame_done;
  logic [15:0] sr;
  logic        hdr_rw, addr_ok;
  logic [4:0]  hdr_addr;

  ad9866_spi_slv_shift u_shift (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sen_n     (sen_n),
    .sdio      (sdio),
    .count_en  (state_q != DONE),
    .fall      (fall),
    .hdr_done  (hdr_done),
    .frame_done(frame_done),
    .sr        (sr)
  );

  // On the 8th rise the header byte sits in sr[7:0]
  assign hdr_rw   = sr[RW_BIT - 8];
  assign hdr_addr = sr[ADDR_MSB - 8 : ADDR_LSB - 8];
  assign addr_ok  = 32'(addr_q) < NREGS;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    regs_d     = regs_q;
    wr_stb_d   = 1'b0;
    addr_err_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (hdr_done) begin
      rw_d   = hdr_rw;
      addr_d = hdr_addr;
    end

    if (frame_done) begin
      if (!addr_ok) begin
        addr_err_d = 1'b1;
      end else if (!rw_q) begin
        regs_d[32'(addr_q)*8 +: 8] = sr[7:0];
        wr_stb_d  = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = sr[7:0];
      end
    end

    if (sen_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = HDR;
        HDR:     if (hdr_done)   state_d = DATA;
        DATA:    if (frame_done) state_d = DONE;
        default: state_d = DONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      addr_q     <= 5'd0;
      regs_q     <= RESET_VAL;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 8'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef AD9866_SPI_READBACK_EN
  logic [7:0] rd_sr_q, rd_sr_d;
  logic       sdo_q, sdo_d;
  logic       unused_ok;

  assign unused_ok = ^sr[15:8];

  always_comb begin
    rd_sr_d = rd_sr_q;
    sdo_d   = sdo_q;
    if (hdr_done && hdr_rw) begin
      rd_sr_d = (32'(hdr_addr) < NREGS) ? regs_q[32'(hdr_addr)*8 +: 8] : 8'h00;
    end
    if (state_q == DATA && fall && rw_q) begin
      sdo_d   = rd_sr_q[7];
      rd_sr_d = {rd_sr_q[6:0], 1'b0};
    end
    // Line is only driven between the header and the 16th rise of a read
    if (sen_n || state_q != DATA) sdo_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_sr_q <= 8'h00;
      sdo_q   <= 1'b0;
    end else begin
      rd_sr_q <= rd_sr_d;
      sdo_q   <= sdo_d;
    end
  end

  assign sdo = sdo_q;
`else
  logic unused_ok;

  assign unused_ok = ^{sr[15:8], fall};
  assign sdo       = 1'b0;
`endif

  assign regs     = regs_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign addr_err = addr_err_q;
  assign rx_gain  = regs_q[RX_GAIN_LSB +: 6];

endmodule

// File: tb/tb_ad9866_spi_responder.sv
// Scoreboard bench for ad9866_spi_responder: frames are bit-banged, expected commits are queued and
// a negedge monitor matches every wr_stb / addr_err pulse against the queue.
module tb_ad9866_spi_responder;

  localparam int NREGS = 20;
`ifdef AD9866_SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset, sclk, sen_n, sdio;
  logic               sdo, wr_stb, addr_err;
  logic [NREGS*8-1:0] regs;
  logic [4:0]         wr_addr;
  logic [7:0]         wr_data;
  logic [5:0]         rx_gain;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         err;
    logic [4:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] model[NREGS];

  ad9866_spi_responder #(.NREGS(NREGS)) dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .sen_n   (sen_n),
    .sdio    (sdio),
    .sdo     (sdo),
    .regs    (regs),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .addr_err(addr_err),
    .rx_gain (rx_gain)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
    ev_t e;
    e.err = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
    model[a] = d;
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.addr = 5'd0; e.data = 8'd0;
    exp_q.push_back(e);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) check(tag, 32'(regs[i*8 +: 8]), 32'(model[i]));
  endtask

  // Master: sdio set in the low phase, sclk high 2 clk, low 2 clk; sdo sampled just before each data rise.
  task automatic frame(input logic [15:0] f, input int nrises, input bit hold, output logic [7:0] rd);
    bit exp_pulse;
    rd = 8'h00;
    exp_pulse = (nrises == 16) && (!f[15] || f[12:8] >= 5'd20);
    sen_n = 1'b0;
    tick(1);
    for (int i = 0; i < nrises; i++) begin
      sdio = f[15-i];
      tick(1);
      if (i >= 8) rd[15-i] = sdo;
      sclk = 1'b1;
      tick(1);
      if (i == 15) check("commit_latency", 32'(wr_stb | addr_err), 32'(exp_pulse));
      tick(1);
      sclk = 1'b0;
      tick(1);
    end
    if (!hold) begin
      sen_n = 1'b1;
      tick(2);
    end
    $display("frame %04h rises=%0d rd=%02h", f, nrises, rd);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (wr_stb || addr_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: wr_stb=%0b addr_err=%0b, expected none", wr_stb, addr_err);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, wr_stb, addr_err}, e.err ? 32'd1 : 32'd2);
        if (!e.err) begin
          check("wr_addr", 32'(wr_addr), 32'(e.addr));
          check("wr_data", 32'(wr_data), 32'(e.data));
          check("reg_visible", 32'(regs[int'(e.addr)*8 +: 8]), 32'(e.data));
          if (e.addr == 5'h0a) check("rx_gain_at_stb", 32'(rx_gain), 32'(e.data[5:0]));
        end
      end
    end
  end

  logic [15:0] init_seq[7] = '{16'h0080, 16'h0721, 16'h084b, 16'h0b20, 16'h0c41, 16'h0d01, 16'h1100};
  logic [7:0]  rd;

  initial begin
    reset = 1'b1; sclk = 1'b0; sen_n = 1'b1; sdio = 1'b0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    tick(3);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check_regs("rst_regs");
    reset = 1'b0;
    tick(2);

    // Master init sequence: seven commits expected in address order
    for (int i = 0; i < 7; i++) begin
      push_wr(init_seq[i][12:8], init_seq[i][7:0]);
      frame(init_seq[i], 16, 1'b0, rd);
    end
    check("init_drain", 32'(exp_q.size()), 32'd0);
    check_regs("init_regs");

    push_wr(5'h0a, 8'h45);
    frame(16'h0a45, 16, 1'b0, rd);
    check("rx_gain_0a45", 32'(rx_gain), 32'h05);
    check("gain_wr_addr", 32'(wr_addr), 32'h0a);
    check("gain_wr_data", 32'(wr_data), 32'h45);

    push_wr(5'h0c, 8'h33);
    frame(16'h0c33, 16, 1'b0, rd);
    frame(16'h8c00, 16, 1'b0, rd);
    check("read_0c", 32'(rd), READBACK ? 32'h33 : 32'h00);
    frame(16'h8700, 16, 1'b0, rd);
    check("read_07", 32'(rd), READBACK ? 32'h21 : 32'h00);
    check("read_drain", 32'(exp_q.size()), 32'd0);
    check_regs("after_read");

    // Partial frame must vanish; the following full frame writes normally
    frame(16'h0bff, 11, 1'b0, rd);
    tick(3);
    check("abort_drain", 32'(exp_q.size()), 32'd0);
    check("abort_reg_b", 32'(regs[8'h0b*8 +: 8]), 32'h20);
    push_wr(5'h0b, 8'h55);
    frame(16'h0b55, 16, 1'b0, rd);
    check("after_abort_b", 32'(regs[8'h0b*8 +: 8]), 32'h55);

    push_err();
    frame(16'h1f12, 16, 1'b0, rd);
    check_regs("addr31_write");
    push_err();
    frame(16'h9f00, 16, 1'b0, rd);
    check("read_31", 32'(rd), 32'h00);
    check("err_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the data phase of a frame, then a clean frame afterwards
    frame(16'h0a7f, 12, 1'b1, rd);
    reset = 1'b1;
    tick(2);
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    check("midrst_sdo", 32'(sdo), 32'd0);
    check("midrst_rx_gain", 32'(rx_gain), 32'd0);
    check_regs("midrst_regs");
    sclk  = 1'b0;
    sen_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    push_wr(5'h0a, 8'h3c);
    frame(16'h0a3c, 16, 1'b0, rd);
    check("post_rst_rx_gain", 32'(rx_gain), 32'h3c);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check_regs("final_regs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
